// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- parameterised UART transmitter.
//
// Accepts one DATA_BITS word per tx_valid/tx_ready handshake. It then sends one
// frame on the tx pin: a start bit, the data bits LSB first, an optional parity
// bit, and STOP_BITS stop bits. Each bit lasts CLK_FREQ/BAUD_RATE clocks.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> parity_mode is honoured and the PARITY state is built
//                (00 none, 01 even, 10 odd, 11 mark).
//   undefined -> the parity logic is not built. parity_mode is ignored and
//                every frame is start + data + stop.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset (drives the line high at once)
//   tx_data      word to send, sampled on acceptance
//   tx_valid     producer has a word on tx_data
//   tx_ready     registered; high only while idle
//   tx           registered serial line, idle high
//   parity_mode  parity selection, sampled on acceptance
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ  = 1_000_000,
    parameter int BAUD_RATE = 10_000,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic [1:0]           parity_mode
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     baud_cnt, baud_nxt;
    logic [3:0]           bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic                 tx_q, tx_nxt;
    logic                 ready_q, ready_nxt;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    // The parity bit is resolved once, at acceptance, from the unshifted word.
    // Later shifting of shift_q then has no effect on it.
    logic par_en_q, par_en_nxt;
    logic par_q, par_nxt;
`else
    logic unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign tx       = tx_q;
    assign tx_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            shift_q  <= shift_nxt;
            tx_q     <= tx_nxt;
            ready_q  <= ready_nxt;
`ifdef UART_TX_PARITY_EN
            par_en_q <= par_en_nxt;
            par_q    <= par_nxt;
`endif
        end
    end

    // The next line level is computed together with the next state. The
    // registered tx_q then changes on the same edge as the bit boundary.
    always_comb begin
        state_nxt = state;
        baud_nxt  = bit_end ? '0 : baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        tx_nxt    = tx_q;
        ready_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_nxt = par_en_q;
        par_nxt    = par_q;
`endif
        unique case (state)
            IDLE: begin
                baud_nxt  = '0;
                bit_nxt   = '0;
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
                if (tx_valid && ready_q) begin
                    state_nxt = START;
                    shift_nxt = tx_data;
                    tx_nxt    = 1'b0;
                    ready_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
                    par_en_nxt = |parity_mode;
                    unique case (parity_mode)
                        2'b01:   par_nxt = ^tx_data;
                        2'b10:   par_nxt = ~^tx_data;
                        default: par_nxt = 1'b1;
                    endcase
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    tx_nxt    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_q;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                    end else begin
                        bit_nxt   = bit_cnt + 1'b1;
                        shift_nxt = shift_q >> 1;
                        tx_nxt    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                        ready_nxt = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
// Instance u_dut1 uses the 8N1 defaults. Instance u_dut2 uses two stop bits.
// Both run at 100 clocks per bit. Expected frames are written out in
// transmission order (leftmost character = first bit on the line).
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int C = 100;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic       valid1, valid2;
    logic       ready1, ready2;
    logic       tx1, tx2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [1:0] pm;
        logic [0:11] bits;
        int         nbits;
    } vec_t;

    vec_t vecs[$];

    uart_tx u_dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid1),
        .tx_ready(ready1), .tx(tx1), .parity_mode(parity_mode)
    );

    uart_tx #(.STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid2),
        .tx_ready(ready2), .tx(tx2), .parity_mode(parity_mode)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic cur_tx(input int sel);
        return (sel == 2) ? tx2 : tx1;
    endfunction

    function automatic logic cur_rdy(input int sel);
        return (sel == 2) ? ready2 : ready1;
    endfunction

    // Call this 1 time unit after the acceptance edge. It checks every cycle of
    // the frame, then the idle state at edge k+N.
    task automatic check_frame(input string name, input int sel,
                               input logic [0:11] bits, input int nbits);
        int n;
        n = nbits * C;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                chk({name, " tx"}, cur_tx(sel), bits[i / C]);
                chk({name, " ready"}, cur_rdy(sel), 1'b0);
                @(posedge clk);
                #1;
            end else begin
                chk({name, " end tx"}, cur_tx(sel), 1'b1);
                chk({name, " end ready"}, cur_rdy(sel), 1'b1);
            end
        end
    endtask

    // One-cycle valid pulse on u_dut1. The inputs are scrambled right after
    // acceptance so that any late sampling shows up in the frame.
    task automatic send1(input logic [7:0] d, input logic [1:0] m);
        @(negedge clk);
        tx_data     = d;
        parity_mode = m;
        valid1      = 1'b1;
        @(posedge clk);
        #1;
        valid1      = 1'b0;
        tx_data     = ~d;
        parity_mode = ~m;
    endtask

    initial begin
        rst_n       = 1'b0;
        valid1      = 1'b0;
        valid2      = 1'b0;
        tx_data     = 8'h00;
        parity_mode = 2'b00;

        vecs.push_back('{"v_aa", 8'hAA, 2'b00, 12'b0010101011_00, 10});
        vecs.push_back('{"v_00", 8'h00, 2'b00, 12'b0000000001_00, 10});
        vecs.push_back('{"v_ff", 8'hFF, 2'b00, 12'b0111111111_00, 10});
        vecs.push_back('{"v_01", 8'h01, 2'b00, 12'b0100000001_00, 10});
        vecs.push_back('{"v_80", 8'h80, 2'b00, 12'b0000000011_00, 10});
`ifdef UART_TX_PARITY_EN
        vecs.push_back('{"par_even", 8'h07, 2'b01, 12'b01110000011_0, 11});
        vecs.push_back('{"par_odd",  8'h07, 2'b10, 12'b01110000001_0, 11});
        vecs.push_back('{"par_mark", 8'h07, 2'b11, 12'b01110000011_0, 11});
        vecs.push_back('{"par_even0", 8'h03, 2'b01, 12'b01100000001_0, 11});
`else
        vecs.push_back('{"pm_ignored", 8'h07, 2'b01, 12'b0111000001_00, 10});
`endif

        // Reset state
        #22;
        chk("rst tx1", tx1, 1'b1);
        chk("rst ready1", ready1, 1'b1);
        chk("rst tx2", tx2, 1'b1);
        chk("rst ready2", ready2, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle tx1", tx1, 1'b1);
            chk("idle ready1", ready1, 1'b1);
        end

        // Table-driven frames on u_dut1
        foreach (vecs[v]) begin
            send1(vecs[v].data, vecs[v].pm);
            check_frame(vecs[v].name, 1, vecs[v].bits, vecs[v].nbits);
        end

        // A valid pulse and a data change while busy must be ignored
        send1(8'h3C, 2'b00);
        fork
            check_frame("busy_3c", 1, 12'b0001111001_00, 10);
            begin
                repeat (300) @(negedge clk);
                tx_data = 8'hFF;
                valid1  = 1'b1;
                @(negedge clk);
                valid1  = 1'b0;
            end
        join
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("busy single tx", tx1, 1'b1);
            chk("busy single ready", ready1, 1'b1);
        end

        // Two stop bits, valid held high: back-to-back frames, one idle cycle apart
        @(negedge clk);
        tx_data     = 8'h55;
        parity_mode = 2'b00;
        valid2      = 1'b1;
        @(posedge clk);
        #1;
        tx_data = 8'h0F;
        check_frame("b2b_55", 2, 12'b01010101011_0, 11);
        @(posedge clk);
        #1;
        check_frame("b2b_0f", 2, 12'b01111000011_0, 11);
        valid2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b after tx2", tx2, 1'b1);
        chk("b2b after ready2", ready2, 1'b1);

        // Asynchronous reset during data bit 3 (frame bit 4, cycles 400..499)
        send1(8'h00, 2'b00);
        repeat (449) @(posedge clk);
        #2;
        chk("pre-abort tx", tx1, 1'b0);
        chk("pre-abort ready", ready1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort tx", tx1, 1'b1);
        chk("abort ready", ready1, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send1(8'h3C, 2'b00);
        check_frame("post_abort", 1, 12'b0001111001_00, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
